// File: rtl/bomberman_draw_engine.sv
// Bomberman draw engine: streams background, tile and player sprites to VGA.
// Define SPRITE_TRANSPARENCY_EN to skip colour-0 pixels of player sprites.
module bomberman_draw_engine #(
  parameter int COLOUR_W  = 3,
  parameter int SCREEN_W  = 160,
  parameter int SCREEN_H  = 120,
  parameter int GRID_COLS = 15,
  parameter int GRID_ROWS = 13,
  parameter int STAGE_X0  = 20,
  parameter int STAGE_Y0  = 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                copy_enable,
  input  logic [1:0]          memory_select,
  input  logic                draw_stage,
  input  logic                draw_t,
  input  logic                draw_p1,
  input  logic                draw_p2,
  input  logic                tc_enable,
  input  logic [7:0]          p1_x,
  input  logic [7:0]          p2_x,
  input  logic [6:0]          p1_y,
  input  logic [6:0]          p2_y,
  input  logic [2:0]          tile_type,
  output logic [3:0]          tile_col,
  output logic [3:0]          tile_row,
  output logic                all_tiles_drawn,
  output logic [1:0]          rom_sel,
  output logic [14:0]         rom_addr,
  input  logic [COLOUR_W-1:0] rom_data,
  output logic [7:0]          vga_x,
  output logic [6:0]          vga_y,
  output logic [COLOUR_W-1:0] vga_colour,
  output logic                vga_plot,
  output logic                finished
);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  state_t      state_q, state_d;
  logic        bg_q, bg_d;
  logic        pl_q, pl_d;
  logic [2:0]  id_q, id_d;
  logic [7:0]  ox_q, ox_d;
  logic [6:0]  oy_q, oy_d;
  logic [1:0]  sel_q, sel_d;
  logic [7:0]  cx_q, cx_d;
  logic [6:0]  cy_q, cy_d;
  logic [7:0]  vx_q, vx_d;
  logic [6:0]  vy_q, vy_d;
  logic        plot_q, plot_d;
  logic [3:0]  col_q, col_d;
  logic [3:0]  row_q, row_d;

  logic [8:0]  sx;
  logic [7:0]  sy;
  logic        in_b;
  logic        x_end;
  logic        last;
  logic        start;
  logic [14:0] bg_addr;

  // Wide sums so sprites hanging off the right/bottom edge never wrap.
  assign sx = {1'b0, ox_q} + {1'b0, cx_q};
  assign sy = {1'b0, oy_q} + {1'b0, cy_q};
  assign in_b = (sx < 9'(SCREEN_W)) && (sy < 8'(SCREEN_H));

  assign x_end = bg_q ? (cx_q == 8'(SCREEN_W - 1))
                      : (cx_q == 8'd7);
  assign last  = x_end && (bg_q ? (cy_q == 7'(SCREEN_H - 1))
                                : (cy_q == 7'd7));

  assign bg_addr = 15'(cy_q) * 15'(SCREEN_W) + 15'(cx_q);

  assign start = (state_q == IDLE) && copy_enable
              && (draw_stage | draw_t | draw_p1 | draw_p2);

  always_comb begin
    state_d = state_q;
    bg_d    = bg_q;
    pl_d    = pl_q;
    id_d    = id_q;
    ox_d    = ox_q;
    oy_d    = oy_q;
    sel_d   = sel_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    vx_d    = vx_q;
    vy_d    = vy_q;
    plot_d  = 1'b0;
    col_d   = col_q;
    row_d   = row_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          sel_d   = memory_select;
          cx_d    = '0;
          cy_d    = '0;
          bg_d    = 1'b0;
          pl_d    = 1'b0;
          priority case (1'b1)
            draw_stage: begin
              bg_d = 1'b1;
              id_d = '0;
              ox_d = '0;
              oy_d = '0;
            end
            draw_t: begin
              id_d = tile_type;
              ox_d = 8'(STAGE_X0) + {1'b0, col_q, 3'b0};
              oy_d = 7'(STAGE_Y0) + {row_q, 3'b0};
            end
            draw_p1: begin
              pl_d = 1'b1;
              id_d = 3'd6;
              ox_d = p1_x;
              oy_d = p1_y;
            end
            default: begin
              pl_d = 1'b1;
              id_d = 3'd7;
              ox_d = p2_x;
              oy_d = p2_y;
            end
          endcase
        end
      end
      RUN: begin
        if (!copy_enable) begin
          state_d = IDLE;
        end else begin
          plot_d = in_b;
          vx_d   = sx[7:0];
          vy_d   = sy[6:0];
          if (x_end) begin
            cx_d = '0;
            cy_d = cy_q + 7'd1;
          end else begin
            cx_d = cx_q + 8'd1;
          end
          if (last) state_d = FLUSH;
        end
      end
      FLUSH: state_d = copy_enable ? DONE : IDLE;
      default: state_d = IDLE;
    endcase

    if (start && draw_stage) begin
      col_d = '0;
      row_d = '0;
    end else if (tc_enable) begin
      if (col_q == 4'(GRID_COLS - 1)) begin
        col_d = '0;
        row_d = (row_q == 4'(GRID_ROWS - 1)) ? '0 : row_q + 4'd1;
      end else begin
        col_d = col_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      bg_q    <= 1'b0;
      pl_q    <= 1'b0;
      id_q    <= '0;
      ox_q    <= '0;
      oy_q    <= '0;
      sel_q   <= '0;
      cx_q    <= '0;
      cy_q    <= '0;
      vx_q    <= '0;
      vy_q    <= '0;
      plot_q  <= 1'b0;
      col_q   <= '0;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      bg_q    <= bg_d;
      pl_q    <= pl_d;
      id_q    <= id_d;
      ox_q    <= ox_d;
      oy_q    <= oy_d;
      sel_q   <= sel_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      vx_q    <= vx_d;
      vy_q    <= vy_d;
      plot_q  <= plot_d;
      col_q   <= col_d;
      row_q   <= row_d;
    end
  end

  assign rom_addr = bg_q ? bg_addr
                         : {6'b0, id_q, cy_q[2:0], cx_q[2:0]};
  assign rom_sel  = sel_q;
  assign tile_col = col_q;
  assign tile_row = row_q;
  assign all_tiles_drawn = (col_q == 4'(GRID_COLS - 1))
                        && (row_q == 4'(GRID_ROWS - 1));
  assign vga_x      = vx_q;
  assign vga_y      = vy_q;
  assign vga_colour = rom_data;
  assign finished   = (state_q == DONE);

`ifdef SPRITE_TRANSPARENCY_EN
  assign vga_plot = plot_q && !(pl_q && (rom_data == '0));
`else
  assign vga_plot = plot_q;
`endif

endmodule

// File: tb/tb_bomberman_draw_engine.sv
// Directed bench for bomberman_draw_engine with a plot scoreboard.
// Honours SPRITE_TRANSPARENCY_EN in its expected-plot model.
module tb_bomberman_draw_engine;

  logic        clock = 1'b0;
  logic        reset;
  logic        copy_enable;
  logic [1:0]  memory_select;
  logic        draw_stage, draw_t, draw_p1, draw_p2;
  logic        tc_enable;
  logic [7:0]  p1_x, p2_x;
  logic [6:0]  p1_y, p2_y;
  logic [2:0]  tile_type;
  logic [3:0]  tile_col, tile_row;
  logic        all_tiles_drawn;
  logic [1:0]  rom_sel;
  logic [14:0] rom_addr;
  logic [2:0]  rom_data = 3'd0;
  logic [7:0]  vga_x;
  logic [6:0]  vga_y;
  logic [2:0]  vga_colour;
  logic        vga_plot;
  logic        finished;

  bomberman_draw_engine dut (
    .clock          (clock),
    .reset          (reset),
    .copy_enable    (copy_enable),
    .memory_select  (memory_select),
    .draw_stage     (draw_stage),
    .draw_t         (draw_t),
    .draw_p1        (draw_p1),
    .draw_p2        (draw_p2),
    .tc_enable      (tc_enable),
    .p1_x           (p1_x),
    .p2_x           (p2_x),
    .p1_y           (p1_y),
    .p2_y           (p2_y),
    .tile_type      (tile_type),
    .tile_col       (tile_col),
    .tile_row       (tile_row),
    .all_tiles_drawn(all_tiles_drawn),
    .rom_sel        (rom_sel),
    .rom_addr       (rom_addr),
    .rom_data       (rom_data),
    .vga_x          (vga_x),
    .vga_y          (vga_y),
    .vga_colour     (vga_colour),
    .vga_plot       (vga_plot),
    .finished       (finished)
  );

  always #5 clock = ~clock;

  int vectors = 0;
  int miscompares = 0;
  int edge_n = 0;
  int fin_cnt = 0;
  int fin_cyc = 0;
  int plots = 0;
  logic [17:0] sb[$];
  logic [17:0] exp_v;

  // Sprite 6 starts with 20 black pixels to exercise transparency.
  function automatic logic [2:0] rom_f(input logic [14:0] a);
    if (a[14:9] == 6'd0 && a[8:6] == 3'd6 && a[5:0] < 6'd20)
      return 3'd0;
    return a[2:0] ^ a[5:3] ^ a[8:6];
  endfunction

  always @(posedge clock) begin
    edge_n   <= edge_n + 1;
    rom_data <= rom_f(rom_addr);
  end

  always @(negedge clock) begin
    if (finished) begin
      fin_cnt++;
      fin_cyc = edge_n + 1;
    end
    if (vga_plot) begin
      plots++;
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $error("FAIL plot_extra: got x=%0d y=%0d c=%0d, none expected",
               vga_x, vga_y, vga_colour);
      end else begin
        exp_v = sb.pop_front();
        assert ({vga_x, vga_y, vga_colour} === exp_v) else begin
          miscompares++;
          $error("FAIL plot: got x=%0d y=%0d c=%0d expected x=%0d y=%0d c=%0d",
                 vga_x, vga_y, vga_colour,
                 exp_v[17:10], exp_v[9:3], exp_v[2:0]);
        end
      end
    end
  end

  task automatic cyc();
    @(negedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic push_sprite(input logic [2:0] id, input int ox,
                             input int oy);
    for (int py = 0; py < 8; py++) begin
      for (int px = 0; px < 8; px++) begin
        int x = ox + px;
        int y = oy + py;
        logic [14:0] a;
        logic [2:0] c;
        logic keep;
        a = {6'd0, id, 3'(py), 3'(px)};
        c = rom_f(a);
        keep = 1'b1;
`ifdef SPRITE_TRANSPARENCY_EN
        keep = !(id >= 3'd6 && c == 3'd0);
`endif
        if (x < 160 && y < 120 && keep)
          sb.push_back({8'(x), 7'(y), c});
      end
    end
  endtask

  task automatic push_stage();
    for (int y = 0; y < 120; y++)
      for (int x = 0; x < 160; x++)
        sb.push_back({8'(x), 7'(y), rom_f(15'(y * 160 + x))});
  endtask

  task automatic start(input logic [1:0] sel, input logic ds,
                       input logic dt, input logic d1, input logic d2,
                       output int s);
    memory_select = sel;
    draw_stage = ds;
    draw_t = dt;
    draw_p1 = d1;
    draw_p2 = d2;
    copy_enable = 1'b1;
    s = edge_n + 1;
  endtask

  task automatic wait_fin(input string tag, input int s, input int n);
    int f0 = fin_cnt;
    logic seen = 1'b0;
    for (int i = 0; i < n + 10 && !seen; i++) begin
      cyc();
      if (fin_cnt != f0) seen = 1'b1;
    end
    chk({tag, "_done"}, 32'(seen), 32'd1);
    chk({tag, "_lat"}, 32'(fin_cyc - s), 32'(n + 2));
  endtask

  task automatic idle_cmd();
    copy_enable = 1'b0;
    draw_stage = 1'b0;
    draw_t = 1'b0;
    draw_p1 = 1'b0;
    draw_p2 = 1'b0;
  endtask

  initial begin
    int s, s2, f0, pc0, pc1, n1, fin1, mc, mr, hits;
    logic reached;
    reset = 1'b1;
    idle_cmd();
    memory_select = 2'd0;
    tc_enable = 1'b0;
    p1_x = 8'd50;
    p1_y = 7'd40;
    p2_x = 8'd156;
    p2_y = 7'd118;
    tile_type = 3'd0;
    repeat (3) cyc();
    reset = 1'b0;
    cyc();

    chk("rst_col", tile_col, 0);
    chk("rst_row", tile_row, 0);
    chk("rst_atd", all_tiles_drawn, 0);
    chk("rst_fin", finished, 0);
    chk("rst_plot", vga_plot, 0);
    chk("rst_addr", rom_addr, 0);
    chk("rst_vx", vga_x, 0);
    chk("rst_vy", vga_y, 0);
    chk("rst_sel", rom_sel, 0);

    // Full-screen background copy.
    push_stage();
    f0 = fin_cnt;
    start(2'd1, 1'b1, 1'b0, 1'b0, 1'b0, s);
    cyc();
    chk("stage_sel", rom_sel, 1);
    chk("stage_addr0", rom_addr, 0);
    wait_fin("stage", s, 19200);
    idle_cmd();
    cyc();
    cyc();
    chk("stage_fin_once", fin_cnt - f0, 1);
    chk("stage_q", sb.size(), 0);
    chk("stage_col", tile_col, 0);
    chk("stage_row", tile_row, 0);

    // Walk the tile counter to (3,2).
    tc_enable = 1'b1;
    repeat (33) cyc();
    tc_enable = 1'b0;
    cyc();
    chk("tc_col32", tile_col, 3);
    chk("tc_row32", tile_row, 2);

    // Tile draw; draw_t outranks draw_p1, later changes are ignored.
    tile_type = 3'd5;
    push_sprite(3'd5, 44, 24);
    start(2'd2, 1'b0, 1'b1, 1'b1, 1'b0, s);
    cyc();
    tile_type = 3'd2;
    draw_t = 1'b0;
    draw_p1 = 1'b0;
    draw_p2 = 1'b1;
    tc_enable = 1'b1;
    cyc();
    tc_enable = 1'b0;
    wait_fin("tile", s, 64);
    idle_cmd();
    cyc();
    cyc();
    chk("tile_q", sb.size(), 0);
    chk("tile_col", tile_col, 4);
    chk("tile_row", tile_row, 2);

    // Reset in the middle of a sprite draw.
    push_sprite(3'd6, 30, 30);
    p1_x = 8'd30;
    p1_y = 7'd30;
    f0 = fin_cnt;
    start(2'd3, 1'b0, 1'b0, 1'b1, 1'b0, s);
    repeat (6) cyc();
    reset = 1'b1;
    idle_cmd();
    cyc();
    chk("mrst_plot", vga_plot, 0);
    chk("mrst_fin", finished, 0);
    chk("mrst_col", tile_col, 0);
    chk("mrst_row", tile_row, 0);
    chk("mrst_sel", rom_sel, 0);
    reset = 1'b0;
    sb.delete();
    repeat (4) cyc();
    chk("mrst_nofin", fin_cnt - f0, 0);

    // 195 pulses sweep every tile once and wrap.
    mc = 0;
    mr = 0;
    hits = 0;
    tc_enable = 1'b1;
    for (int i = 0; i < 195; i++) begin
      chk("atd", all_tiles_drawn, 32'(mc == 14 && mr == 12));
      if (all_tiles_drawn) hits++;
      if (mc == 14) begin
        mc = 0;
        mr = (mr == 12) ? 0 : mr + 1;
      end else begin
        mc++;
      end
      cyc();
    end
    tc_enable = 1'b0;
    cyc();
    chk("atd_hits", hits, 1);
    chk("wrap_col", tile_col, 0);
    chk("wrap_row", tile_row, 0);

    // Back-to-back p1 then p2 (p1 outranks p2); p2 clipped to 4x2.
    p1_x = 8'd50;
    p1_y = 7'd40;
    push_sprite(3'd6, 50, 40);
    n1 = sb.size();
    push_sprite(3'd7, 156, 118);
    pc0 = plots;
    start(2'd3, 1'b0, 1'b0, 1'b1, 1'b1, s);
    wait_fin("p1", s, 64);
    draw_p1 = 1'b0;
    fin1 = fin_cyc;
    s2 = edge_n + 2;
    pc1 = plots;
`ifdef SPRITE_TRANSPARENCY_EN
    chk("p1_plots", pc1 - pc0, n1);
`else
    chk("p1_plots", pc1 - pc0, 64);
`endif
    wait_fin("p2", s2, 64);
    idle_cmd();
    cyc();
    cyc();
    chk("p2_plots", plots - pc1, 8);
    chk("b2b_gap", fin_cyc - fin1, 67);
    chk("b2b_q", sb.size(), 0);

    // Abort after 10 pixels.
    p1_x = 8'd70;
    p1_y = 7'd60;
    push_sprite(3'd6, 70, 60);
    pc0 = plots;
    f0 = fin_cnt;
    start(2'd3, 1'b0, 1'b0, 1'b1, 1'b0, s);
    reached = 1'b0;
    for (int i = 0; i < 40 && !reached; i++) begin
      cyc();
      if (plots - pc0 >= 10) reached = 1'b1;
    end
    chk("abort_reach", reached, 1);
    idle_cmd();
    cyc();
    chk("abort_plot", vga_plot, 0);
    sb.delete();
    repeat (80) cyc();
    chk("abort_nofin", fin_cnt - f0, 0);
    chk("abort_plots", plots - pc0, 10);

    // Fresh draw after the abort.
    p2_x = 8'd10;
    p2_y = 7'd20;
    push_sprite(3'd7, 10, 20);
    f0 = fin_cnt;
    start(2'd3, 1'b0, 1'b0, 1'b0, 1'b1, s);
    wait_fin("p2b", s, 64);
    idle_cmd();
    cyc();
    cyc();
    chk("p2b_fin_once", fin_cnt - f0, 1);
    chk("p2b_q", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
